// File: rtl/nn_layer_engine_pkg.sv
// Shared fixed-point definitions, enums and the activation/saturation
// helper for the dense-layer engine.
package nn_layer_engine_pkg;

    localparam int Q_INT     = 8;
    localparam int Q_FRAC    = 8;
    localparam int Q_SIZE    = Q_INT + Q_FRAC;
    localparam int ACC_GUARD = 8;
    localparam int ACC_W     = Q_SIZE + ACC_GUARD;

    typedef enum logic [1:0] {
        ACT_IDENT  = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_HTANH  = 2'd2,
        ACT_IDENT3 = 2'd3
    } act_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_BIAS,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_ONE     = ACC_W'(1 << Q_FRAC);
    localparam logic signed [ACC_W-1:0] ACC_NEG_ONE = -ACC_ONE;
    localparam logic signed [ACC_W-1:0] ACC_QMAX    = ACC_W'((1 << (Q_SIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_QMIN    = ~ACC_QMAX;

    // Activation runs on the wide accumulator so the clamp sees the true value
    // before it is squeezed into a Q_SIZE word.
    function automatic logic [Q_SIZE-1:0] sat_act(input logic signed [ACC_W-1:0] acc,
                                                  input act_mode_t mode);
        logic signed [ACC_W-1:0] v;
        v = acc;
        case (mode)
            ACT_RELU: begin
                if (acc[ACC_W-1]) v = '0;
            end
            ACT_HTANH: begin
                if (acc > ACC_ONE) v = ACC_ONE;
                else if (acc < ACC_NEG_ONE) v = ACC_NEG_ONE;
            end
            default: v = acc;
        endcase
        if (v > ACC_QMAX) sat_act = {1'b0, {(Q_SIZE - 1){1'b1}}};
        else if (v < ACC_QMIN) sat_act = {1'b1, {(Q_SIZE - 1){1'b0}}};
        else sat_act = v[Q_SIZE-1:0];
    endfunction

endpackage

// File: rtl/nn_layer_engine_lane_mac.sv
// One MAC lane: fixed-point product rescaled by Q_FRAC (floor), accumulated
// into an ACC_W register that wraps on overflow.
module nn_lane_mac
    import nn_layer_engine_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [Q_SIZE-1:0] x,
    input  logic signed [Q_SIZE-1:0] w,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*Q_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]    term;

    assign prod = (2*Q_SIZE)'(x) * (2*Q_SIZE)'(w);
    assign term = ACC_W'(prod >>> Q_FRAC);

    always_ff @(posedge clk) begin
        if (reset || clear) acc <= '0;
        else if (en) acc <= acc + term;
    end

endmodule

// File: rtl/nn_layer_engine.sv
// Dense layer engine: y = act(W.x + b), neurons tiled over NU_COUNT lanes,
// results streamed out on a valid/ready port.
module nn_layer_engine
    import nn_layer_engine_pkg::*;
#(
    parameter int NU_COUNT = 4,
    parameter int X_DEPTH  = 8,
    parameter int W_DEPTH  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [X_DEPTH-1:0]           cfg_in_count,
    input  logic [X_DEPTH-1:0]           cfg_out_count,
    input  logic [X_DEPTH-1:0]           cfg_x_base,
    input  logic [X_DEPTH-1:0]           cfg_y_base,
    input  logic [1:0]                   cfg_act_mode,
    output logic                         busy,
    output logic                         done,
    output logic [X_DEPTH-1:0]           x_read_addr,
    input  logic [Q_SIZE-1:0]            x_read_data,
    output logic [W_DEPTH-1:0]           w_read_addr,
    input  logic [NU_COUNT*Q_SIZE-1:0]   w_read_data,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [X_DEPTH-1:0]           y_addr,
    output logic [Q_SIZE-1:0]            y_data
);

    localparam int LANE_W = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;
    localparam logic [Q_SIZE-1:0] X_ONE = Q_SIZE'(1 << Q_FRAC);

    state_t                  state;
    act_mode_t               act_mode;
    logic [X_DEPTH-1:0]      in_cnt, x_base, y_base, k_cnt, rem_cnt, y_tile;
    logic [W_DEPTH-1:0]      w_tile;
    logic [LANE_W-1:0]       lane;
    logic                    acc_en, acc_bias;
    logic [Q_SIZE-1:0]       x_op;
    logic                    lane_last, tile_last;
    logic signed [ACC_W-1:0] acc [NU_COUNT];

    // Read data arrives one cycle after the address, so accumulate/bias flags
    // are the previous cycle's state delayed by one register.
    assign x_op      = acc_bias ? X_ONE : x_read_data;
    assign lane_last = (lane == LANE_W'(NU_COUNT - 1)) ||
                       ((X_DEPTH'(lane) + X_DEPTH'(1)) == rem_cnt);
    assign tile_last = (rem_cnt <= X_DEPTH'(NU_COUNT));
    assign y_data    = sat_act(acc[lane], act_mode);

    for (genvar i = 0; i < NU_COUNT; i++) begin : g_lane
        nn_lane_mac u_mac (
            .clk   (clk),
            .reset (reset),
            .clear (state == ST_CLEAR),
            .en    (acc_en),
            .x     (x_op),
            .w     (w_read_data[i*Q_SIZE +: Q_SIZE]),
            .acc   (acc[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            act_mode    <= ACT_IDENT;
            busy        <= 1'b0;
            done        <= 1'b0;
            y_valid     <= 1'b0;
            y_addr      <= '0;
            x_read_addr <= '0;
            w_read_addr <= '0;
            in_cnt      <= '0;
            x_base      <= '0;
            y_base      <= '0;
            k_cnt       <= '0;
            rem_cnt     <= '0;
            y_tile      <= '0;
            w_tile      <= '0;
            lane        <= '0;
            acc_en      <= 1'b0;
            acc_bias    <= 1'b0;
        end else begin
            acc_en   <= (state == ST_MAC) || (state == ST_BIAS);
            acc_bias <= (state == ST_BIAS);
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_cnt   <= cfg_in_count;
                        x_base   <= cfg_x_base;
                        y_base   <= cfg_y_base;
                        act_mode <= act_mode_t'(cfg_act_mode);
                        rem_cnt  <= cfg_out_count;
                        w_tile   <= '0;
                        y_tile   <= '0;
                        busy     <= 1'b1;
                        if (cfg_out_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    x_read_addr <= x_base;
                    w_read_addr <= w_tile;
                    k_cnt       <= '0;
                    state       <= (in_cnt == '0) ? ST_BIAS : ST_MAC;
                end
                ST_MAC: begin
                    // The final increment lands w_read_addr on the bias word.
                    x_read_addr <= x_read_addr + X_DEPTH'(1);
                    w_read_addr <= w_read_addr + W_DEPTH'(1);
                    k_cnt       <= k_cnt + X_DEPTH'(1);
                    if (k_cnt == in_cnt - X_DEPTH'(1)) state <= ST_BIAS;
                end
                ST_BIAS: state <= ST_DRAIN;
                ST_DRAIN: begin
                    y_valid <= 1'b1;
                    y_addr  <= y_base + y_tile;
                    lane    <= '0;
                    state   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (y_ready) begin
                        if (lane_last) begin
                            y_valid <= 1'b0;
                            if (tile_last) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                rem_cnt <= rem_cnt - X_DEPTH'(NU_COUNT);
                                w_tile  <= w_tile + W_DEPTH'(in_cnt) + W_DEPTH'(1);
                                y_tile  <= y_tile + X_DEPTH'(NU_COUNT);
                                state   <= ST_CLEAR;
                            end
                        end else begin
                            lane   <= lane + LANE_W'(1);
                            y_addr <= y_addr + X_DEPTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
